port_wakeup: RTL and testbench



---
 rtl/port_wakeup_pkg.sv | 22 ++
 rtl/pwk_sync.sv | 70 +++++++
 rtl/port_wakeup.sv | 126 ++++++++++++
 tb/tb_port_wakeup.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/port_wakeup_pkg.sv
// Shared constants for the port wake-up block: register addresses, ctrl bit
// positions and the FSM state encoding.
package port_wakeup_pkg;

  localparam logic [3:0] PWK_MSK7_A = 4'hB;
  localparam logic [3:0] PWK_MSK8_A = 4'hC;
  localparam logic [3:0] PWK_MSK9_A = 4'hD;
  localparam logic [3:0] PWK_MSKA_A = 4'hE;
  localparam logic [3:0] PWK_CTRL_A = 4'hF;

  localparam int CTRL_GIE    = 0;
  localparam int CTRL_RESNAP = 1;
  localparam int CTRL_CLR    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    PEND = 2'd2,
    ACK  = 2'd3
  } pwk_state_t;

endpackage

// File: rtl/pwk_sync.sv
// Per-nibble pad synchroniser; with PWK_DEBOUNCE_EN defined a stability
// counter sits behind it and only forwards values held DEBOUNCE_CYC cycles.
module pwk_sync #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);

  localparam bit CFG_OK = (SYNC_STAGES >= 2) && (SYNC_STAGES <= 3) &&
                          (DEBOUNCE_CYC >= 1) && (DEBOUNCE_CYC <= 15);

  if (!CFG_OK) begin : g_bad_cfg
    $error("pwk_sync: SYNC_STAGES must be 2..3 and DEBOUNCE_CYC 1..15");
  end

  logic [3:0] stg [SYNC_STAGES];
  logic [3:0] raw;

  // Pads idle high, so every stage resets to all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) stg[i] <= 4'hf;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign raw = stg[SYNC_STAGES-1];

`ifdef PWK_DEBOUNCE_EN
  logic [3:0] acc;
  logic [3:0] cand;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;

  // cnt counts consecutive cycles that raw has held one value different from acc.
  always_comb begin
    cnt_nxt = 4'd1;
    if ((raw == cand) && (cnt != 4'd0)) cnt_nxt = cnt + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= 4'hf;
      cand <= 4'hf;
      cnt  <= 4'd0;
    end else if (raw == acc) begin
      cnt  <= 4'd0;
      cand <= acc;
    end else if (cnt_nxt == 4'(DEBOUNCE_CYC)) begin
      acc  <= raw;
      cand <= raw;
      cnt  <= 4'd0;
    end else begin
      cand <= raw;
      cnt  <= cnt_nxt;
    end
  end

  assign q = acc;
`else
  assign q = raw;
`endif

endmodule

// File: rtl/port_wakeup.sv
// Pin-change wake-up/interrupt stage for GPIO ports 7, 8, 9 and A.
// Optional pad debounce is built in when PWK_DEBOUNCE_EN is defined.
module port_wakeup
  import port_wakeup_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sync,
  input  logic [3:0] datai,
  input  logic [3:0] acci,
  input  logic [3:0] port7_i,
  input  logic [3:0] port8_i,
  input  logic [3:0] port9_i,
  input  logic [3:0] porta_i,
  input  logic       irq_ack,
  output logic       irq,
  output logic [3:0] pwk_mux
);

  // Port index order everywhere: 0 = port7, 1 = port8, 2 = port9, 3 = portA.
  logic [3:0] pad  [4];
  logic [3:0] s    [4];
  logic [3:0] snap [4];
  logic [3:0] msk  [4];
  logic [3:0] pend;
  logic [3:0] pend_nxt;
  logic [3:0] hit;
  logic       gie;
  logic       wr_ctrl;
  logic       clr_wr;
  logic       resnap_wr;
  logic       gie_off_wr;
  logic       snap_load;

  pwk_state_t state;
  pwk_state_t state_nxt;

  assign pad[0] = port7_i;
  assign pad[1] = port8_i;
  assign pad[2] = port9_i;
  assign pad[3] = porta_i;

  for (genvar g = 0; g < 4; g++) begin : g_port
    pwk_sync #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (pad[g]),
      .q   (s[g])
    );
  end

  assign wr_ctrl    = sync && (datai == PWK_CTRL_A);
  assign clr_wr     = wr_ctrl && acci[CTRL_CLR];
  assign resnap_wr  = wr_ctrl && acci[CTRL_RESNAP];
  assign gie_off_wr = wr_ctrl && !acci[CTRL_GIE];

  always_comb begin
    hit = 4'h0;
    for (int p = 0; p < 4; p++) hit[p] = |((s[p] ^ snap[p]) & msk[p]);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (gie) state_nxt = ARM;
      ARM:  if (|hit) state_nxt = PEND;
      PEND: if (irq_ack) state_nxt = ACK;
      ACK:  if (clr_wr) state_nxt = ARM;
      default: state_nxt = IDLE;
    endcase
    if (!gie || gie_off_wr) state_nxt = IDLE;
  end

  // A hit on the same edge as CLR survives because it is ORed in after the clear.
  always_comb begin
    pend_nxt = clr_wr ? 4'h0 : pend;
    if (state != IDLE) pend_nxt = pend_nxt | hit;
  end

  assign snap_load = (state == IDLE) || resnap_wr ||
                     ((state == PEND) && (state_nxt == ACK));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pend  <= 4'h0;
      gie   <= 1'b0;
      for (int p = 0; p < 4; p++) begin
        snap[p] <= 4'hf;
        msk[p]  <= 4'h0;
      end
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      if (wr_ctrl) gie <= acci[CTRL_GIE];
      if (sync && (datai == PWK_MSK7_A)) msk[0] <= acci;
      if (sync && (datai == PWK_MSK8_A)) msk[1] <= acci;
      if (sync && (datai == PWK_MSK9_A)) msk[2] <= acci;
      if (sync && (datai == PWK_MSKA_A)) msk[3] <= acci;
      if (snap_load) begin
        for (int p = 0; p < 4; p++) snap[p] <= s[p];
      end
    end
  end

  assign irq = (state == PEND);

  always_comb begin
    pwk_mux = 4'h0;
    case (datai)
      PWK_MSK7_A: pwk_mux = msk[0];
      PWK_MSK8_A: pwk_mux = msk[1];
      PWK_MSK9_A: pwk_mux = msk[2];
      PWK_MSKA_A: pwk_mux = msk[3];
      PWK_CTRL_A: pwk_mux = pend;
      default:    pwk_mux = 4'h0;
    endcase
  end

endmodule

// File: tb/tb_port_wakeup.sv
// Directed bench for port_wakeup: register table plus hand-written wake-up,
// acknowledge, CLR/hit race, debounce and reset sequences.
module tb_port_wakeup;

  localparam int SS = 2;
  localparam int DC = 8;
`ifdef PWK_DEBOUNCE_EN
  localparam int LAT = SS + DC + 1;
`else
  localparam int LAT = SS + 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sync = 1'b0;
  logic [3:0] datai = 4'h0;
  logic [3:0] acci = 4'h0;
  logic [3:0] port7_i = 4'hf;
  logic [3:0] port8_i = 4'hf;
  logic [3:0] port9_i = 4'hf;
  logic [3:0] porta_i = 4'hf;
  logic       irq_ack = 1'b0;
  logic       irq;
  logic [3:0] pwk_mux;

  int total = 0;
  int bad = 0;

  port_wakeup #(.SYNC_STAGES(SS), .DEBOUNCE_CYC(DC)) dut (
    .clk     (clk),
    .rst     (rst),
    .sync    (sync),
    .datai   (datai),
    .acci    (acci),
    .port7_i (port7_i),
    .port8_i (port8_i),
    .port9_i (port9_i),
    .porta_i (porta_i),
    .irq_ack (irq_ack),
    .irq     (irq),
    .pwk_mux (pwk_mux)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       do_wr;
    logic [3:0] addr;
    logic [3:0] wdata;
    logic [3:0] exp_rd;
  } vec_t;

  vec_t vecs [14];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] addr, input logic [3:0] data);
    sync  = 1'b1;
    datai = addr;
    acci  = data;
    tick();
    sync  = 1'b0;
  endtask

  task automatic rd(input string name, input logic [3:0] addr, input logic [3:0] exp);
    datai = addr;
    #1;
    check(name, pwk_mux, exp);
  endtask

  // Counts edges until irq is seen high; -1 when the budget runs out.
  task automatic wait_irq(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (irq === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic ack_pulse();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    int n;

    vecs[0]  = '{1'b0, 4'hB, 4'h0, 4'h0};
    vecs[1]  = '{1'b0, 4'hC, 4'h0, 4'h0};
    vecs[2]  = '{1'b0, 4'hD, 4'h0, 4'h0};
    vecs[3]  = '{1'b0, 4'hE, 4'h0, 4'h0};
    vecs[4]  = '{1'b0, 4'hF, 4'h0, 4'h0};
    vecs[5]  = '{1'b0, 4'h7, 4'h0, 4'h0};
    vecs[6]  = '{1'b1, 4'hB, 4'h5, 4'h5};
    vecs[7]  = '{1'b1, 4'hC, 4'hA, 4'hA};
    vecs[8]  = '{1'b1, 4'hD, 4'h3, 4'h3};
    vecs[9]  = '{1'b1, 4'hE, 4'hC, 4'hC};
    vecs[10] = '{1'b0, 4'hA, 4'h0, 4'h0};
    vecs[11] = '{1'b0, 4'h0, 4'h0, 4'h0};
    vecs[12] = '{1'b1, 4'hB, 4'h0, 4'h0};
    vecs[13] = '{1'b0, 4'hF, 4'h0, 4'h0};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_irq", {3'b0, irq}, 4'h0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
      rd($sformatf("vec%0d_rd_%h", i, vecs[i].addr), vecs[i].addr, vecs[i].exp_rd);
    end
    wr(4'hC, 4'h0);
    wr(4'hD, 4'h0);
    wr(4'hE, 4'h0);

    // Arm on port8 bit1 only; a masked-off bit must not wake.
    wr(4'hC, 4'b0010);
    wr(4'hF, 4'b0001);
    repeat (3) tick();
    port8_i = 4'b1110;
    repeat (LAT + 2) tick();
    check("masked_irq", {3'b0, irq}, 4'h0);
    rd("masked_pend", 4'hF, 4'h0);

    port8_i = 4'b1100;
    wait_irq(LAT + 10, n);
    check("wake_latency", 4'(n), 4'(LAT));
    rd("wake_pend", 4'hF, 4'b0010);

    ack_pulse();
    check("ack_irq_low", {3'b0, irq}, 4'h0);

    wr(4'hD, 4'h8);
    port9_i = 4'b0111;
    repeat (LAT + 1) tick();
    check("ack_new_hit_irq", {3'b0, irq}, 4'h0);
    rd("ack_new_hit_pend", 4'hF, 4'b0110);
    port9_i = 4'hf;
    repeat (LAT + 1) tick();
    wr(4'hF, 4'b1001);
    rd("clr_pend", 4'hF, 4'h0);
    check("clr_irq", {3'b0, irq}, 4'h0);

    // Back in ARM: a fresh change against the ACK-entry snapshot wakes again.
    port8_i = 4'b1110;
    wait_irq(LAT + 10, n);
    check("rearm_latency", 4'(n), 4'(LAT));
    rd("rearm_pend", 4'hF, 4'b0010);

    ack_pulse();
    wr(4'hF, 4'b1001);
    wr(4'hE, 4'hf);
    porta_i = 4'b0111;
    repeat (LAT - 1) tick();
    wr(4'hF, 4'b1001);
    rd("clr_vs_hit_pend", 4'hF, 4'b1000);
    check("clr_vs_hit_irq", {3'b0, irq}, 4'h1);

    wr(4'hF, 4'b0000);
    check("gie_off_irq", {3'b0, irq}, 4'h0);
    rd("gie_off_pend_kept", 4'hF, 4'b1000);
    wr(4'hE, 4'h0);
    rd("mask_clear_pend_kept", 4'hF, 4'b1000);
    wr(4'hF, 4'b1000);
    rd("idle_clr_pend", 4'hF, 4'h0);

    wr(4'hB, 4'h1);
    wr(4'hF, 4'b0001);
    repeat (3) tick();
`ifdef PWK_DEBOUNCE_EN
    port7_i = 4'he;
    repeat (5) tick();
    port7_i = 4'hf;
    repeat (LAT + 8) tick();
    check("glitch_irq", {3'b0, irq}, 4'h0);
    rd("glitch_pend", 4'hF, 4'h0);
`endif
    port7_i = 4'he;
    wait_irq(LAT + 10, n);
    check("port7_latency", 4'(n), 4'(LAT));

    rst = 1'b1;
    #1;
    check("async_rst_irq", {3'b0, irq}, 4'h0);
    rd("rst_pend", 4'hF, 4'h0);
    rd("rst_msk7", 4'hB, 4'h0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_irq", {3'b0, irq}, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

endmodule
